i2s_rx: RTL
===========

// Module: i2s_rx
// PURPOSE
//  I2S slave receiver. Consumes the bclk/wclk produced by the I2S clock generator plus serial ADC data.
//  Oversamples all three pins on the 100 MHz system clock and deserializes standard I2S (MSB first, 1-bit WS delay).
//  Delivers left/right sample pairs on a valid/ready interface to the DSP path.
// PARAMETERS
//  SAMPLE_W   16   bits kept per channel; default matches 32 bclk per wclk period
//  SYNC_STG   2    synchronizer flops on bclk/wclk/sdin (>=2)
//  CNT_W      6    width of saturating per-slot bit counter (slot <= 2**CNT_W-1 bits)
// PORTS
//  clk        in   1         system clock, 100 MHz
//  reset      in   1         asynchronous, active-low reset
//  bclk       in   1         I2S bit clock, async to clk, half-period >= 4 clk
//  wclk       in   1         I2S word select: 0 = left, 1 = right; async
//  sdin       in   1         I2S serial data; async
//  out_left   out  SAMPLE_W  left sample, two's complement
//  out_right  out  SAMPLE_W  right sample, two's complement
//  out_valid  out  1         pair held in output register
//  out_ready  in   1         consumer accepts the pair when out_valid && out_ready
//  overrun    out  1         1-clk pulse: a completed pair was dropped because the output was full
//  frame_err  out  1         1-clk pulse: a slot ended with fewer than SAMPLE_W bits
// BEHAVIOUR
//  - Reset (reset=0): all outputs 0; state ALIGN; shift register, counter, and held left sample cleared.
//    Takes effect immediately, also mid-word; a partial word is discarded.
//  - bclk, wclk, and sdin pass through identical SYNC_STG flop chains. A bclk rising edge is detected one clk after it
//    leaves the chain ("tick"). On a tick, ws/sd are the synchronized wclk/sdin values; ws_prev is ws from the previous tick.
//  - Per tick: if cnt < SAMPLE_W, shift sd in at LSB and increment cnt (saturating). Extra slot bits are ignored (LSB padding).
//  - Boundary tick (ws != ws_prev): this tick's sd is the LSB of the finished word.
//    The word includes this tick's shift. After capture, shift reg and cnt are cleared.
//  - States:
//    ALIGN: ignore data until boundary ws 1->0, then enter LEFT. Discard that word and raise no error.
//    LEFT:  on boundary 0->1: if cnt(incl. this tick) < SAMPLE_W, pulse frame_err and go to ALIGN.
//           Otherwise store left_hold and go to RIGHT.
//    RIGHT: on boundary 1->0: if short, pulse frame_err and go to ALIGN. Otherwise emit {left_hold, word} and go to LEFT.
//  - Emit: if !out_valid or out_ready in the same clk, load out_left/out_right and set out_valid the next clk.
//    Otherwise keep the old pair, drop the new one, and pulse overrun.
//  - out_valid clears the clk after out_valid && out_ready unless an emit coincides. The register reloads and valid stays 1.
//  - Latency: bclk pin edge of the right LSB -> out_valid = SYNC_STG + 2 clk (4 at default).
//  - out_left/out_right are stable while out_valid=1 and are not modified by later frames until accepted.
// STRUCTURE
//  - i2s_pkg: typedef enum {ALIGN, LEFT, RIGHT} i2s_rx_state_t; localparam I2S_SAMPLE_W = 16.
//  - Sub-module i2s_sync: SYNC_STG-deep flop chain, instantiated 3x (bclk, wclk, sdin).
//  - Top: tick detector, shift reg + counter, FSM, and output holding register.
// TESTING
//  Use a bench clock model with bclk period 64 clk and wclk period 2048 clk (16 bits/slot), plus an I2S serial driver.
//  1. Frames L=0xA5C3, R=0x1234 with out_ready=1 -> after the ALIGN frame, out_left=A5C3, out_right=1234.
//     out_valid rises 4 clk after the right-LSB bclk edge and lasts 1 clk.
//  2. out_ready=0 for 3 frames -> first pair held unchanged. overrun pulses once per dropped frame.
//     Raising ready accepts the first pair, then valid=0.
//  3. Assert reset mid-left slot -> outputs 0 at once. After release, first valid pair comes only after a fresh ws 1->0 alignment.
//  4. Corrupt one left slot to 8 bits -> frame_err pulse, no out_valid for that frame, clean pair after next 1->0 boundary.
//  5. Slots of 24 bits (L=0xABCDEF, R=0x123456) -> out_left=ABCD, out_right=1234, no errors.
//  6. Pair completes in the same clk that out_valid && out_ready -> new pair loaded, out_valid stays 1, no overrun.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S slave receiver.
package i2s_pkg;

  localparam int I2S_SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ALIGN,
    LEFT,
    RIGHT
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchronizer for one asynchronous I2S pin.
module i2s_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversampled pins, MSB-first deserializer, left/right pair output with valid/ready.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = I2S_SAMPLE_W,
  parameter int SYNC_STG = 2,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk,
  input  logic                wclk,
  input  logic                sdin,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  output logic                frame_err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_W);

  logic                bclk_s, ws_s, sd_s;
  logic                bclk_d, tick, ws, sd, ws_prev;
  logic [SAMPLE_W-1:0] shift, shift_nx, left_hold;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                word_done, slot_short, emit;
  i2s_rx_state_t       state;

  i2s_sync #(.STAGES(SYNC_STG)) u_sync_bclk (.clk(clk), .reset(reset), .d(bclk), .q(bclk_s));
  i2s_sync #(.STAGES(SYNC_STG)) u_sync_wclk (.clk(clk), .reset(reset), .d(wclk), .q(ws_s));
  i2s_sync #(.STAGES(SYNC_STG)) u_sync_sdin (.clk(clk), .reset(reset), .d(sdin), .q(sd_s));

  // Registered edge detect; ws/sd are captured alongside so all three stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_d <= 1'b0;
      tick   <= 1'b0;
      ws     <= 1'b0;
      sd     <= 1'b0;
    end else begin
      bclk_d <= bclk_s;
      tick   <= bclk_s & ~bclk_d;
      ws     <= ws_s;
      sd     <= sd_s;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shift_nx   = shift;
    cnt_nx     = cnt;
    if (cnt < FULL_CNT) begin
      shift_nx = {shift[SAMPLE_W-2:0], sd};
      cnt_nx   = cnt + CNT_W'(1);
    end
    word_done  = tick && (ws != ws_prev);
    slot_short = cnt_nx < FULL_CNT;
    emit       = word_done && (state == RIGHT) && !slot_short;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ALIGN;
      ws_prev   <= 1'b0;
      shift     <= '0;
      cnt       <= '0;
      left_hold <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (tick) begin
        ws_prev <= ws;
        if (word_done) begin
          shift <= '0;
          cnt   <= '0;
        end else begin
          shift <= shift_nx;
          cnt   <= cnt_nx;
        end
      end
      if (word_done) begin
        unique case (state)
          ALIGN: if (!ws) state <= LEFT;
          LEFT: begin
            if (slot_short) begin
              frame_err <= 1'b1;
              state     <= ALIGN;
            end else begin
              left_hold <= shift_nx;
              state     <= RIGHT;
            end
          end
          RIGHT: begin
            if (slot_short) begin
              frame_err <= 1'b1;
              state     <= ALIGN;
            end else begin
              state     <= LEFT;
            end
          end
          default: state <= ALIGN;
        endcase
      end
    end
  end

  // A held pair is never overwritten until the consumer takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (emit) begin
        if (!out_valid || out_ready) begin
          out_left  <= left_hold;
          out_right <= shift_nx;
          out_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
